// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard and pipeline-state controller for a five-stage
// (F/D/E/M/W) pipeline.
//
// The block decodes the instruction codes and status codes of the stages
// behind fetch. From them it derives stall and bubble requests: load-use,
// return, branch mispredict and exception. A small FSM (RUN / DRAIN / HALT)
// handles an exceptional instruction that is draining out of memory and
// writeback.
//
// Ports
//   clk         in   1   clock; all state changes on the rising edge
//   reset       in   1   synchronous, active-high
//   D_icode     in   4   instruction code in decode
//   E_icode     in   4   instruction code in execute
//   M_icode     in   4   instruction code in memory
//   E_dstM      in   4   load destination register in execute
//   d_srcA      in   4   decode source register A
//   d_srcB      in   4   decode source register B
//   e_Cnd       in   1   branch condition evaluated in execute (1 = taken)
//   m_stat      in   4   status code leaving memory
//   W_stat      in   4   status code in writeback
//   F_stall     out  1   hold the fetch register
//   D_stall     out  1   hold the decode register
//   D_bubble    out  1   inject a bubble into decode
//   E_bubble    out  1   inject a bubble into execute
//   M_bubble    out  1   inject a bubble into memory
//   W_stall     out  1   hold the writeback register
//   halted      out  1   pipeline has stopped
//   pipe_state  out  2   FSM state (0 RUN, 1 DRAIN, 2 HALT)
//
// Optional feature (macro PIPE_CTRL_PERF_EN)
//   cyc_cnt     out 32   non-HALT cycles, saturating
//   stall_cnt   out 32   RUN cycles with F_stall, saturating
//   bubble_cnt  out 32   RUN cycles with E_bubble, saturating
//
// All control outputs are combinational from the inputs and the registered
// state, so a hazard is acted on in the same cycle it appears.
// -----------------------------------------------------------------------------
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic        e_Cnd,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        halted,
    output logic [1:0]  pipe_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    // Status codes
    localparam logic [3:0] SAOK    = 4'd1;
    localparam logic [3:0] SHLT    = 4'd2;
    localparam logic [3:0] SADR    = 4'd3;
    localparam logic [3:0] SINS    = 4'd4;
    // Instruction codes
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPOPQ   = 4'd11;
    // "No register"
    localparam logic [3:0] RNONE   = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    // An exceptional status code is one of halt, bad address or bad instruction.
    function automatic logic is_exc_stat(input logic [3:0] stat);
        is_exc_stat = (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

    state_t r_state;
    state_t w_next_state;

    logic w_lu;
    logic w_ret;
    logic w_mp;
    logic w_exc;
    logic w_m_not_aok;
    logic w_w_not_aok;

    logic w_f_stall;
    logic w_d_stall;
    logic w_d_bubble;
    logic w_e_bubble;
    logic w_m_bubble;
    logic w_w_stall;
    logic w_halted;
    logic [1:0] w_pipe_state;

    // Hazard detection from the stage codes
    always_comb begin
        w_lu        = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                      (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        w_ret       = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        w_mp        = (E_icode == IJXX) && (e_Cnd == 1'b0);
        w_exc       = is_exc_stat(m_stat) || is_exc_stat(W_stat);
        w_m_not_aok = (m_stat != SAOK);
        w_w_not_aok = (W_stat != SAOK);
    end

    // FSM state register; reset always returns to RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; writeback status takes priority over memory status
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_w_not_aok) begin
                    w_next_state = ST_HALT;
                end else if (w_m_not_aok) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_w_not_aok) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                // The unused code falls back to the safe stopped state
                w_next_state = ST_HALT;
            end
        endcase
    end

    // Control outputs from the hazards and the current state; reset overrides all
    always_comb begin
        w_f_stall    = 1'b0;
        w_d_stall    = 1'b0;
        w_d_bubble   = 1'b0;
        w_e_bubble   = 1'b0;
        w_m_bubble   = 1'b0;
        w_w_stall    = 1'b0;
        w_halted     = 1'b0;
        w_pipe_state = r_state;
        if (reset) begin
            w_d_bubble   = 1'b1;
            w_e_bubble   = 1'b1;
            w_m_bubble   = 1'b1;
            w_pipe_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_f_stall  = w_lu || w_ret;
                    // A mispredict squashes decode, so decode must not also be held
                    w_d_stall  = w_lu && !w_mp;
                    // Load-use wins over return: decode is held rather than bubbled
                    w_d_bubble = w_mp || (w_ret && !w_lu);
                    w_e_bubble = w_mp || w_lu;
                    w_m_bubble = w_exc;
                    w_w_stall  = 1'b0;
                end
                ST_DRAIN: begin
                    w_f_stall  = 1'b1;
                    w_d_stall  = 1'b0;
                    w_d_bubble = 1'b1;
                    w_e_bubble = 1'b1;
                    w_m_bubble = 1'b1;
                    w_w_stall  = 1'b0;
                end
                ST_HALT: begin
                    w_f_stall  = 1'b1;
                    w_d_stall  = 1'b1;
                    w_d_bubble = 1'b0;
                    w_e_bubble = 1'b0;
                    w_m_bubble = 1'b1;
                    w_w_stall  = 1'b1;
                    w_halted   = 1'b1;
                end
                default: begin
                    // The unused code behaves as HALT for the single cycle it can last
                    w_f_stall  = 1'b1;
                    w_d_stall  = 1'b1;
                    w_d_bubble = 1'b0;
                    w_e_bubble = 1'b0;
                    w_m_bubble = 1'b1;
                    w_w_stall  = 1'b1;
                    w_halted   = 1'b1;
                end
            endcase
        end
    end

    // Drive the ports from the combinational control signals
    always_comb begin
        F_stall    = w_f_stall;
        D_stall    = w_d_stall;
        D_bubble   = w_d_bubble;
        E_bubble   = w_e_bubble;
        M_bubble   = w_m_bubble;
        W_stall    = w_w_stall;
        halted     = w_halted;
        pipe_state = w_pipe_state;
    end

`ifdef PIPE_CTRL_PERF_EN
    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc32 = val;
        end else begin
            sat_inc32 = val + 32'd1;
        end
    endfunction

    logic [31:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic        w_cnt_active;
    logic        w_in_run;

    // Which cycles count: any running or draining cycle, and RUN-only events
    always_comb begin
        w_cnt_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        w_in_run     = (r_state == ST_RUN);
    end

    // Saturating performance counters, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt    <= 32'd0;
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_cnt_active) begin
                r_cyc_cnt <= sat_inc32(r_cyc_cnt);
            end else begin
                r_cyc_cnt <= r_cyc_cnt;
            end
            if (w_in_run && w_f_stall) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_in_run && w_e_bubble) begin
                r_bubble_cnt <= sat_inc32(r_bubble_cnt);
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

    // Counter ports
    always_comb begin
        cyc_cnt    = r_cyc_cnt;
        stall_cnt  = r_stall_cnt;
        bubble_cnt = r_bubble_cnt;
    end
`endif

endmodule
